// File: rtl/ipu_frame_sched.sv
// ipu_frame_sched
//   Frame-level controller for the IPU centroid datapath. It sits between the
//   CCD capture stream and the IPU. It does four things:
//     - passes the pixel-valid stream to the IPU only for whole frames;
//     - pulses an accumulator clear on the start-of-frame (SOF) pixel;
//     - double-buffers the RGB thresholds so they change only at an SOF;
//     - collects the frame's centroid, or a timeout no-detect, and holds it
//       for the consumer on a valid/ready handshake.
//
// Ports
//   iCLK, iRST             clock, synchronous active-low reset
//   iEnable                run request from host
//   iDVAL, iX_Cont/iY_Cont capture pixel valid and position
//   iCfg_we/addr/data      threshold writes (0=R 1=G 2=B, 3 ignored)
//   oIPU_DVAL, oIPU_clr    gated pixel valid and accumulator clear (combinational)
//   oThr_R/G/B             active thresholds
//   iIPU_DVAL/Row/Col      IPU centroid result
//   oRes_*, iRes_ready     result handshake to the consumer
//   oFrame_cnt             results delivered (wraps)
//   oDrop_cnt              frames skipped or truncated (saturates at 255)
//
// State table
//   state    | meaning
//   IDLE     | not running; IPU stream gated off
//   WAIT_SOF | armed; the next SOF pixel starts a frame
//   STREAM   | frame in progress; pixels pass to the IPU
//   WAIT_RES | frame ended; waiting for the IPU result or a timeout
//   HOLD     | result presented; waiting for consumer ready

module ipu_frame_sched #(
  parameter int          FRAME_W     = 640,
  parameter int          FRAME_H     = 480,
  parameter int          RES_TIMEOUT = 1024,
  parameter logic [11:0] THR_DEFAULT = 12'hC00
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEnable,
  input  logic        iDVAL,
  input  logic [10:0] iX_Cont,
  input  logic [10:0] iY_Cont,
  input  logic        iCfg_we,
  input  logic [1:0]  iCfg_addr,
  input  logic [11:0] iCfg_data,
  output logic        oIPU_DVAL,
  output logic        oIPU_clr,
  output logic [11:0] oThr_R,
  output logic [11:0] oThr_G,
  output logic [11:0] oThr_B,
  input  logic        iIPU_DVAL,
  input  logic [10:0] iIPU_Row,
  input  logic [10:0] iIPU_Col,
  output logic        oRes_valid,
  output logic        oRes_found,
  output logic [10:0] oRes_row,
  output logic [10:0] oRes_col,
  input  logic        iRes_ready,
  output logic [15:0] oFrame_cnt,
  output logic [7:0]  oDrop_cnt
);

  localparam logic [10:0] X_LAST   = 11'(FRAME_W - 1);
  localparam logic [10:0] Y_LAST   = 11'(FRAME_H - 1);
  localparam int          TW       = (RES_TIMEOUT > 1) ? $clog2(RES_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(RES_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_STREAM,
    S_WAIT_RES,
    S_HOLD
  } state_t;

  state_t      state;
  logic [11:0] stage_r, stage_g, stage_b;
  logic [TW-1:0] tmo_cnt;

  logic sof, eof;
  logic drop_hit;

  assign sof = iDVAL && (iX_Cont == 11'd0) && (iY_Cont == 11'd0);
  assign eof = iDVAL && (iX_Cont == X_LAST) && (iY_Cont == Y_LAST);

  // Pixel gating and clear must line up with the SOF pixel itself, so they
  // are decoded from the current state rather than registered.
  always_comb begin
    oIPU_DVAL = 1'b0;
    oIPU_clr  = 1'b0;
    drop_hit  = 1'b0;
    unique case (state)
      S_WAIT_SOF: begin
        if (iEnable && sof) begin
          oIPU_DVAL = 1'b1;
          oIPU_clr  = 1'b1;
        end
      end
      S_STREAM: begin
        oIPU_DVAL = iDVAL;
        oIPU_clr  = sof && !eof;
        drop_hit  = sof && !eof;
      end
      S_WAIT_RES, S_HOLD: begin
        // SOF arriving while a result is outstanding: that frame is lost
        // and the IPU is left alone.
        drop_hit = sof;
      end
      default: begin
        oIPU_DVAL = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state      <= S_IDLE;
      stage_r    <= THR_DEFAULT;
      stage_g    <= THR_DEFAULT;
      stage_b    <= THR_DEFAULT;
      oThr_R     <= THR_DEFAULT;
      oThr_G     <= THR_DEFAULT;
      oThr_B     <= THR_DEFAULT;
      tmo_cnt    <= '0;
      oRes_valid <= 1'b0;
      oRes_found <= 1'b0;
      oRes_row   <= '0;
      oRes_col   <= '0;
      oFrame_cnt <= '0;
      oDrop_cnt  <= '0;
    end else begin
      // Staging always takes writes; the active copy is loaded from the
      // pre-edge staging value, so a write coincident with SOF waits a frame.
      if (iCfg_we) begin
        case (iCfg_addr)
          2'd0:    stage_r <= iCfg_data;
          2'd1:    stage_g <= iCfg_data;
          2'd2:    stage_b <= iCfg_data;
          default: ;
        endcase
      end

      if (drop_hit && (oDrop_cnt != 8'hFF))
        oDrop_cnt <= oDrop_cnt + 8'd1;

      unique case (state)
        S_IDLE: begin
          if (iEnable)
            state <= S_WAIT_SOF;
        end

        S_WAIT_SOF: begin
          if (!iEnable) begin
            state <= S_IDLE;
          end else if (sof) begin
            oThr_R <= stage_r;
            oThr_G <= stage_g;
            oThr_B <= stage_b;
            state  <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (eof) begin
            tmo_cnt <= TMO_LOAD;
            state   <= S_WAIT_RES;
          end else if (sof) begin
            // Truncated frame: restart with fresh thresholds.
            oThr_R <= stage_r;
            oThr_G <= stage_g;
            oThr_B <= stage_b;
          end
        end

        S_WAIT_RES: begin
          if (iIPU_DVAL) begin
            oRes_found <= 1'b1;
            oRes_row   <= iIPU_Row;
            oRes_col   <= iIPU_Col;
            oRes_valid <= 1'b1;
            state      <= S_HOLD;
          end else if (tmo_cnt == '0) begin
            oRes_found <= 1'b0;
            oRes_row   <= '0;
            oRes_col   <= '0;
            oRes_valid <= 1'b1;
            state      <= S_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt - 1'b1;
          end
        end

        S_HOLD: begin
          if (iRes_ready) begin
            oRes_valid <= 1'b0;
            oFrame_cnt <= oFrame_cnt + 16'd1;
            state      <= iEnable ? S_WAIT_SOF : S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipu_frame_sched.sv
module tb_ipu_frame_sched;

  localparam int W     = 16;
  localparam int H     = 8;
  localparam int TMO   = 32;
  localparam int LIMIT = 4 * TMO + 50;

  logic        iCLK;
  logic        iRST;
  logic        iEnable;
  logic        iDVAL;
  logic [10:0] iX_Cont, iY_Cont;
  logic        iCfg_we;
  logic [1:0]  iCfg_addr;
  logic [11:0] iCfg_data;
  logic        oIPU_DVAL, oIPU_clr;
  logic [11:0] oThr_R, oThr_G, oThr_B;
  logic        iIPU_DVAL;
  logic [10:0] iIPU_Row, iIPU_Col;
  logic        oRes_valid, oRes_found;
  logic [10:0] oRes_row, oRes_col;
  logic        iRes_ready;
  logic [15:0] oFrame_cnt;
  logic [7:0]  oDrop_cnt;

  ipu_frame_sched #(
    .FRAME_W(W), .FRAME_H(H), .RES_TIMEOUT(TMO), .THR_DEFAULT(12'hC00)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iEnable(iEnable),
    .iDVAL(iDVAL), .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .iCfg_we(iCfg_we), .iCfg_addr(iCfg_addr), .iCfg_data(iCfg_data),
    .oIPU_DVAL(oIPU_DVAL), .oIPU_clr(oIPU_clr),
    .oThr_R(oThr_R), .oThr_G(oThr_G), .oThr_B(oThr_B),
    .iIPU_DVAL(iIPU_DVAL), .iIPU_Row(iIPU_Row), .iIPU_Col(iIPU_Col),
    .oRes_valid(oRes_valid), .oRes_found(oRes_found),
    .oRes_row(oRes_row), .oRes_col(oRes_col), .iRes_ready(iRes_ready),
    .oFrame_cnt(oFrame_cnt), .oDrop_cnt(oDrop_cnt)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic        found;
    logic [10:0] row;
    logic [10:0] col;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_frames = 0;
  int   exp_drop = 0;

  // Scoreboard: every handshake pops the oldest expected result.
  always @(negedge iCLK) begin : sb_mon
    res_t got, want;
    if (iRST && oRes_valid && iRes_ready) begin
      got = {oRes_found, oRes_row, oRes_col};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_result got=%h required=none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL sb_result got=%h required=%h", got, want);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout got=running required=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic run_frame(input int trunc_y, input int cfg_at,
                           input logic [1:0] ca, input logic [11:0] cd,
                           input int dis_at,
                           output int n_clr, output int n_dval,
                           output logic [35:0] thr0, output logic [35:0] thr1);
    int total;
    int j;
    n_clr  = 0;
    n_dval = 0;
    thr0   = '0;
    thr1   = '0;
    total  = trunc_y * W + W * H;
    for (int p = 0; p < total; p++) begin
      j = (p < trunc_y * W) ? p : p - trunc_y * W;
      iDVAL     = 1'b1;
      iX_Cont   = 11'(j % W);
      iY_Cont   = 11'(j / W);
      iCfg_we   = (p == cfg_at);
      iCfg_addr = ca;
      iCfg_data = cd;
      if (p == dis_at) iEnable = 1'b0;
      #1;
      if (oIPU_clr)  n_clr++;
      if (oIPU_DVAL) n_dval++;
      if (p == 0) thr0 = {oThr_R, oThr_G, oThr_B};
      if (p == 1) thr1 = {oThr_R, oThr_G, oThr_B};
      tick();
    end
    iDVAL   = 1'b0;
    iCfg_we = 1'b0;
    iX_Cont = '0;
    iY_Cont = '0;
  endtask

  task automatic ipu_respond(input logic [10:0] row, input logic [10:0] col);
    tick();
    tick();
    iIPU_DVAL = 1'b1;
    iIPU_Row  = row;
    iIPU_Col  = col;
    exp_q.push_back({1'b1, row, col});
    tick();
    iIPU_DVAL = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!oRes_valid && cyc < LIMIT) begin
      tick();
      cyc++;
    end
  endtask

  task automatic accept();
    iRes_ready = 1'b1;
    tick();
    iRes_ready = 1'b0;
    exp_frames++;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [11:0] d);
    iCfg_we   = 1'b1;
    iCfg_addr = a;
    iCfg_data = d;
    tick();
    iCfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    iRST = 1'b0;
    tick();
    iEnable = 1'b1;
    iDVAL   = 1'b1;
    iX_Cont = '0;
    iY_Cont = '0;
    #1;
    n_cmp++;
    if (oIPU_DVAL !== 1'b0 || oIPU_clr !== 1'b0) begin
      n_err++;
      $display("FAIL reset_gate got=%b%b required=00", oIPU_DVAL, oIPU_clr);
    end
    tick();
    n_cmp++;
    if ({oRes_valid, oRes_found, oRes_row, oRes_col} !== 24'd0) begin
      n_err++;
      $display("FAIL reset_result got=%b/%b/%0d/%0d required=0/0/0/0",
               oRes_valid, oRes_found, oRes_row, oRes_col);
    end
    n_cmp++;
    if (oFrame_cnt !== 16'd0 || oDrop_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_counters got=%0d/%0d required=0/0", oFrame_cnt, oDrop_cnt);
    end
    n_cmp++;
    if ({oThr_R, oThr_G, oThr_B} !== {12'hC00, 12'hC00, 12'hC00}) begin
      n_err++;
      $display("FAIL reset_thr got=%h/%h/%h required=c00/c00/c00", oThr_R, oThr_G, oThr_B);
    end
    iEnable = 1'b0;
    iDVAL   = 1'b0;
    iRST    = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int nc, nd, cyc;
    logic [35:0] t0, t1;
    iEnable = 1'b1;
    tick();
    run_frame(0, -1, 2'd0, 12'h0, -1, nc, nd, t0, t1);
    n_cmp++;
    if (nc !== 1) begin
      n_err++;
      $display("FAIL basic_clr_pulses got=%0d required=1", nc);
    end
    n_cmp++;
    if (nd !== W * H) begin
      n_err++;
      $display("FAIL basic_dval_count got=%0d required=%0d", nd, W * H);
    end
    ipu_respond(11'd100, 11'd200);
    wait_valid(cyc);
    n_cmp++;
    if (cyc >= LIMIT) begin
      n_err++;
      $display("FAIL basic_wait_valid got=timeout required=valid");
    end
    n_cmp++;
    if ({oRes_found, oRes_row, oRes_col} !== {1'b1, 11'd100, 11'd200}) begin
      n_err++;
      $display("FAIL basic_result got=%b/%0d/%0d required=1/100/200",
               oRes_found, oRes_row, oRes_col);
    end
    accept();
    n_cmp++;
    if (oFrame_cnt !== 16'(exp_frames) || oRes_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_accept got=%0d/%b required=%0d/0", oFrame_cnt, oRes_valid, exp_frames);
    end
  endtask

  task automatic test_cfg();
    int nc, nd, cyc;
    logic [35:0] t0, t1;
    // Mid-frame write must not disturb the running frame.
    run_frame(0, 20, 2'd0, 12'h800, -1, nc, nd, t0, t1);
    n_cmp++;
    if (t1[35:24] !== 12'hC00 || oThr_R !== 12'hC00) begin
      n_err++;
      $display("FAIL cfg_midframe got=%h/%h required=c00/c00", t1[35:24], oThr_R);
    end
    ipu_respond(11'd1, 11'd1);
    wait_valid(cyc);
    accept();
    // Write coincident with SOF: this frame gets the older staged value.
    run_frame(0, 0, 2'd0, 12'h456, -1, nc, nd, t0, t1);
    n_cmp++;
    if (t0[35:24] !== 12'hC00 || t1[35:24] !== 12'h800) begin
      n_err++;
      $display("FAIL cfg_sof_load got=%h->%h required=c00->800", t0[35:24], t1[35:24]);
    end
    ipu_respond(11'd2, 11'd2);
    wait_valid(cyc);
    accept();
    run_frame(0, 5, 2'd3, 12'h111, -1, nc, nd, t0, t1);
    n_cmp++;
    if (t1 !== {12'h456, 12'hC00, 12'hC00}) begin
      n_err++;
      $display("FAIL cfg_sof_coincident got=%h required=456c00c00", t1);
    end
    ipu_respond(11'd3, 11'd3);
    wait_valid(cyc);
    accept();
    cfg_write(2'd1, 12'h0AB);
    cfg_write(2'd2, 12'h0CD);
    run_frame(0, -1, 2'd0, 12'h0, -1, nc, nd, t0, t1);
    n_cmp++;
    if (t0 !== {12'h456, 12'hC00, 12'hC00} || t1 !== {12'h456, 12'h0AB, 12'h0CD}) begin
      n_err++;
      $display("FAIL cfg_gb_addr3 got=%h->%h required=456c00c00->4560ab0cd", t0, t1);
    end
    ipu_respond(11'd4, 11'd4);
    wait_valid(cyc);
    accept();
  endtask

  task automatic test_timeout();
    int nc, nd, cyc;
    logic [35:0] t0, t1;
    run_frame(0, -1, 2'd0, 12'h0, -1, nc, nd, t0, t1);
    exp_q.push_back({1'b0, 11'd0, 11'd0});
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== TMO) begin
      n_err++;
      $display("FAIL timeout_latency got=%0d required=%0d", cyc, TMO);
    end
    n_cmp++;
    if ({oRes_found, oRes_row, oRes_col} !== 23'd0) begin
      n_err++;
      $display("FAIL timeout_fields got=%b/%0d/%0d required=0/0/0",
               oRes_found, oRes_row, oRes_col);
    end
    accept();
    n_cmp++;
    if (oFrame_cnt !== 16'(exp_frames)) begin
      n_err++;
      $display("FAIL timeout_frame_cnt got=%0d required=%0d", oFrame_cnt, exp_frames);
    end
  endtask

  task automatic test_hold_drop();
    int nc, nd, cyc;
    logic [35:0] t0, t1;
    run_frame(0, -1, 2'd0, 12'h0, -1, nc, nd, t0, t1);
    ipu_respond(11'd7, 11'd9);
    wait_valid(cyc);
    for (int f = 0; f < 3; f++) begin
      run_frame(0, -1, 2'd0, 12'h0, -1, nc, nd, t0, t1);
      exp_drop++;
      n_cmp++;
      if (nc !== 0 || nd !== 0) begin
        n_err++;
        $display("FAIL hold_skipped_gate f=%0d got=%0d/%0d required=0/0", f, nc, nd);
      end
    end
    n_cmp++;
    if (oDrop_cnt !== 8'(exp_drop)) begin
      n_err++;
      $display("FAIL hold_drop_cnt got=%0d required=%0d", oDrop_cnt, exp_drop);
    end
    n_cmp++;
    if ({oRes_valid, oRes_found, oRes_row, oRes_col} !== {1'b1, 1'b1, 11'd7, 11'd9}) begin
      n_err++;
      $display("FAIL hold_result_stable got=%b/%b/%0d/%0d required=1/1/7/9",
               oRes_valid, oRes_found, oRes_row, oRes_col);
    end
    accept();
  endtask

  task automatic test_trunc();
    int nc, nd, cyc;
    logic [35:0] t0, t1;
    run_frame(3, -1, 2'd0, 12'h0, -1, nc, nd, t0, t1);
    exp_drop++;
    n_cmp++;
    if (nc !== 2 || nd !== 3 * W + W * H) begin
      n_err++;
      $display("FAIL trunc_gate got=%0d/%0d required=2/%0d", nc, nd, 3 * W + W * H);
    end
    n_cmp++;
    if (oDrop_cnt !== 8'(exp_drop)) begin
      n_err++;
      $display("FAIL trunc_drop_cnt got=%0d required=%0d", oDrop_cnt, exp_drop);
    end
    ipu_respond(11'd33, 11'd44);
    wait_valid(cyc);
    accept();
    n_cmp++;
    if (oFrame_cnt !== 16'(exp_frames) || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL trunc_one_result got=%0d/q%0d required=%0d/q0",
               oFrame_cnt, exp_q.size(), exp_frames);
    end
  endtask

  task automatic test_enable_off();
    int nc, nd, cyc;
    logic [35:0] t0, t1;
    run_frame(0, -1, 2'd0, 12'h0, 30, nc, nd, t0, t1);
    n_cmp++;
    if (nc !== 1 || nd !== W * H) begin
      n_err++;
      $display("FAIL enoff_frame_completes got=%0d/%0d required=1/%0d", nc, nd, W * H);
    end
    ipu_respond(11'd5, 11'd6);
    wait_valid(cyc);
    accept();
    n_cmp++;
    if (oFrame_cnt !== 16'(exp_frames)) begin
      n_err++;
      $display("FAIL enoff_frame_cnt got=%0d required=%0d", oFrame_cnt, exp_frames);
    end
    run_frame(0, -1, 2'd0, 12'h0, -1, nc, nd, t0, t1);
    n_cmp++;
    if (nc !== 0 || nd !== 0 || oDrop_cnt !== 8'(exp_drop)) begin
      n_err++;
      $display("FAIL enoff_idle got=%0d/%0d/%0d required=0/0/%0d", nc, nd, oDrop_cnt, exp_drop);
    end
    iEnable = 1'b1;
    tick();
  endtask

  task automatic test_drop_sat();
    int nc, nd, cyc;
    logic [35:0] t0, t1;
    run_frame(0, -1, 2'd0, 12'h0, -1, nc, nd, t0, t1);
    ipu_respond(11'd1, 11'd2);
    wait_valid(cyc);
    for (int k = 0; k < 260; k++) begin
      iDVAL = 1'b1;
      tick();
      iDVAL = 1'b0;
      tick();
      if (exp_drop < 255) exp_drop++;
    end
    n_cmp++;
    if (oDrop_cnt !== 8'(exp_drop)) begin
      n_err++;
      $display("FAIL drop_saturate got=%0d required=%0d", oDrop_cnt, exp_drop);
    end
  endtask

  task automatic test_reset_hold();
    int nc, nd, cyc;
    logic [35:0] t0, t1;
    n_cmp++;
    if (oRes_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rsthold_precondition got=%b required=1", oRes_valid);
    end
    iRST = 1'b0;
    tick();
    exp_q.delete();
    exp_frames = 0;
    exp_drop   = 0;
    n_cmp++;
    if ({oRes_valid, oRes_found, oRes_row, oRes_col, oFrame_cnt, oDrop_cnt,
         oIPU_DVAL, oIPU_clr} !== 50'd0) begin
      n_err++;
      $display("FAIL rsthold_outputs got=%b/%b/%0d/%0d/%0d/%0d required=all 0",
               oRes_valid, oRes_found, oRes_row, oRes_col, oFrame_cnt, oDrop_cnt);
    end
    n_cmp++;
    if ({oThr_R, oThr_G, oThr_B} !== {12'hC00, 12'hC00, 12'hC00}) begin
      n_err++;
      $display("FAIL rsthold_thr got=%h/%h/%h required=c00/c00/c00", oThr_R, oThr_G, oThr_B);
    end
    iRST = 1'b1;
    tick();
    tick();
    run_frame(0, -1, 2'd0, 12'h0, -1, nc, nd, t0, t1);
    ipu_respond(11'd12, 11'd34);
    wait_valid(cyc);
    accept();
    n_cmp++;
    if (oFrame_cnt !== 16'(exp_frames) || nc !== 1) begin
      n_err++;
      $display("FAIL rsthold_restart got=%0d/%0d required=%0d/1", oFrame_cnt, nc, exp_frames);
    end
  endtask

  initial begin
    iRST       = 1'b0;
    iEnable    = 1'b0;
    iDVAL      = 1'b0;
    iX_Cont    = '0;
    iY_Cont    = '0;
    iCfg_we    = 1'b0;
    iCfg_addr  = '0;
    iCfg_data  = '0;
    iIPU_DVAL  = 1'b0;
    iIPU_Row   = '0;
    iIPU_Col   = '0;
    iRes_ready = 1'b0;

    test_reset();
    test_basic();
    test_cfg();
    test_timeout();
    test_hold_drop();
    test_trunc();
    test_enable_off();
    test_drop_sat();
    test_reset_hold();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover got=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
